// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator: PC register, next-PC select, one-entry pending redirect buffer.
// Optional fetch-window check on pc_adel is enabled by defining F_PC_RANGE_CHECK_EN.
module f_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        stall,
  input  logic        md_stall,
  input  logic        jump,
  input  logic [25:0] imm26,
  input  logic        jr,
  input  logic [31:0] ra,
  input  logic        branch,
  input  logic        cmp,
  output logic [31:0] pc,
  output logic        pc_adel,
  output logic        pend_valid
);

`ifdef F_PC_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  localparam logic [31:0] IM_LIMIT = IM_BASE + IM_SIZE;

  logic [31:0] pend_target;
  logic [31:0] tgt;
  logic [31:0] br_off;
  logic        live_redir;
  logic        frz;
  logic [31:0] next_pc;
  logic        next_pend_valid;
  logic [31:0] next_pend_target;
  logic        next_adel;

  assign br_off     = {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign live_redir = eret | jump | jr | (branch & cmp);
  assign frz        = stall | md_stall;

  // Redirect target; pc here is the delay-slot address for branches.
  always_comb begin
    tgt = pc + br_off;
    if (eret)      tgt = epc;
    else if (jump) tgt = {pc[31:28], imm26, 2'b00};
    else if (jr)   tgt = ra;
  end

  always_comb begin
    next_pc          = pc + 32'd4;
    next_pend_valid  = pend_valid;
    next_pend_target = pend_target;
    if (req) begin
      next_pc         = EXC_PC;
      next_pend_valid = 1'b0;
    end else if (frz) begin
      next_pc = pc;
      // Only ERET may replace an already buffered redirect.
      if (live_redir && !pend_valid) begin
        next_pend_target = tgt;
        next_pend_valid  = 1'b1;
      end else if (live_redir && pend_valid && eret) begin
        next_pend_target = epc;
      end
    end else if (pend_valid) begin
      next_pc         = pend_target;
      next_pend_valid = 1'b0;
    end else if (live_redir) begin
      next_pc = tgt;
    end
  end

  // Flag is computed from the value being loaded so it stays aligned with pc.
  always_comb begin
    next_adel = (next_pc[1:0] != 2'b00) |
                (RANGE_EN & ((next_pc < IM_BASE) | (next_pc >= IM_LIMIT)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      pc_adel     <= 1'b0;
    end else begin
      pc          <= next_pc;
      pend_valid  <= next_pend_valid;
      pend_target <= next_pend_target;
      pc_adel     <= next_adel;
    end
  end

endmodule
